// File: rtl/wdt_timer_core.sv
// Watchdog timer core: prescaled up-counter with compare-based expiry,
// one-shot or auto-reload operation, early-warning level and sticky timeout flag.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | not counting; counter holds, prescaler parked at 0
// ST_RUN     | prescaler advancing, counter steps on each tick
// ST_EXPIRED | one-shot expiry reached; counter frozen until a kick
module wdt_timer_core #(
   parameter int WIDTH   = 32,
   parameter int PRESC_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               enable_i,
   input  logic               clear_i,
   input  logic               mode_i,
   input  logic [WIDTH-1:0]   init_value_i,
   input  logic [PRESC_W-1:0] prescale_i,
   input  logic [WIDTH-1:0]   warn_value_i,
   input  logic [WIDTH-1:0]   timeout_value_i,
   input  logic               irq_ack_i,
   output logic [WIDTH-1:0]   counter_value_o,
   output logic               warn_o,
   output logic               timeout_o,
   output logic               timeout_sticky_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   cnt_q, cnt_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               warn_q, warn_d;
   logic               timeout_q, timeout_d;
   logic               sticky_q, sticky_d;
   logic               tick;
   logic               expire;

   // >= rather than == so a prescale lowered mid-count cannot strand the divider
   assign tick   = (state_q == ST_RUN) && enable_i && !clear_i && (presc_q >= prescale_i);
   assign expire = tick && (cnt_q == timeout_value_i);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      presc_d = '0;
      if (clear_i) begin
         cnt_d   = init_value_i;
         state_d = enable_i ? ST_RUN : ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable_i) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (!enable_i) begin
                  state_d = ST_IDLE;
               end else if (expire) begin
                  if (mode_i) cnt_d = init_value_i;
                  else        state_d = ST_EXPIRED;
               end else if (tick) begin
                  if (cnt_q != '1) cnt_d = cnt_q + WIDTH'(1);
               end else begin
                  presc_d = presc_q + PRESC_W'(1);
               end
            end
            ST_EXPIRED: begin
               state_d = ST_EXPIRED;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
      timeout_d = expire;
      sticky_d  = expire | (sticky_q & ~irq_ack_i);
      warn_d    = (state_d == ST_RUN) && (cnt_d >= warn_value_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         presc_q   <= '0;
         warn_q    <= 1'b0;
         timeout_q <= 1'b0;
         sticky_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         presc_q   <= presc_d;
         warn_q    <= warn_d;
         timeout_q <= timeout_d;
         sticky_q  <= sticky_d;
      end
   end

   assign counter_value_o  = cnt_q;
   assign warn_o           = warn_q;
   assign timeout_o        = timeout_q;
   assign timeout_sticky_o = sticky_q;

endmodule

// File: tb/tb_wdt_timer_core.sv
// Bench for wdt_timer_core: directed scenarios plus randomized traffic,
// all outputs compared each cycle against a behavioural model.
module tb_wdt_timer_core;

   localparam int W      = 8;
   localparam int PW     = 4;
   localparam int CMAX   = (1 << W) - 1;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_EXP  = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0, clr = 1'b0, mode = 1'b0, ack = 1'b0;
   logic [W-1:0]  init_v = '0, warn_v = '0, tmo_v = '0;
   logic [PW-1:0] presc = '0;
   logic [W-1:0]  cnt_o;
   logic          warn_o, tmo_o, sticky_o;

   int n_chk = 0;
   int n_fail = 0;

   int m_st, m_cnt, m_div;
   bit m_warn, m_to, m_sticky;

   always #5 clk = ~clk;

   wdt_timer_core #(.WIDTH(W), .PRESC_W(PW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr), .mode_i(mode),
      .init_value_i(init_v), .prescale_i(presc), .warn_value_i(warn_v),
      .timeout_value_i(tmo_v), .irq_ack_i(ack), .counter_value_o(cnt_o),
      .warn_o(warn_o), .timeout_o(tmo_o), .timeout_sticky_o(sticky_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = M_IDLE; m_cnt = 0; m_div = 0;
      m_warn = 0; m_to = 0; m_sticky = 0;
   endtask

   // One clock of the watchdog as described by its rules, using the current inputs.
   task automatic model_clock();
      bit fire = 0;
      int nst = m_st;
      int ncnt = m_cnt;
      int ndiv = 0;
      if (clr) begin
         ncnt = int'(init_v);
         nst  = en ? M_RUN : M_IDLE;
      end else if (m_st == M_IDLE) begin
         nst = en ? M_RUN : M_IDLE;
      end else if (m_st == M_RUN) begin
         if (!en) nst = M_IDLE;
         else if (m_div == int'(presc)) begin
            if (m_cnt == int'(tmo_v)) begin
               fire = 1;
               if (mode) ncnt = int'(init_v);
               else      nst = M_EXP;
            end else begin
               ncnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
            end
         end else begin
            ndiv = m_div + 1;
         end
      end
      m_to     = fire;
      m_sticky = fire || (m_sticky && !ack);
      m_st     = nst;
      m_cnt    = ncnt;
      m_div    = (nst == M_RUN) ? ndiv : 0;
      m_warn   = (nst == M_RUN) && (ncnt >= int'(warn_v));
   endtask

   task automatic step();
      model_clock();
      @(posedge clk);
      #1;
      chk("cnt", cnt_o, m_cnt);
      chk("warn", warn_o, m_warn);
      chk("timeout", tmo_o, m_to);
      chk("sticky", sticky_o, m_sticky);
   endtask

   // Called at edge+1: reset is asserted and checked between edges.
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      chk("rst_cnt", cnt_o, 0);
      chk("rst_warn", warn_o, 0);
      chk("rst_timeout", tmo_o, 0);
      chk("rst_sticky", sticky_o, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic cfg(input int p, input int iv, input int tv, input int wv, input bit md);
      presc = PW'(p); init_v = W'(iv); tmo_v = W'(tv); warn_v = W'(wv); mode = md;
      en = 0; clr = 0; ack = 0;
   endtask

   initial begin
      int n;
      model_reset();
      #1;
      do_reset();

      // one-shot expiry
      cfg(0, 0, 5, 0, 0);
      en = 1;
      repeat (6) step();
      chk("d38_cnt5", cnt_o, 5);
      chk("d38_no_pulse_yet", tmo_o, 0);
      step();
      chk("d38_pulse", tmo_o, 1);
      chk("d38_sticky", sticky_o, 1);
      chk("d38_hold", cnt_o, 5);
      step();
      chk("d38_pulse_end", tmo_o, 0);
      chk("d38_warn_exp", warn_o, 0);
      chk("d38_hold2", cnt_o, 5);

      // auto-reload
      do_reset();
      cfg(0, 2, 5, 255, 1);
      en = 1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (tmo_o) n++;
      end
      chk("d39_pulses", n, 4);
      chk("d39_sticky", sticky_o, 1);
      ack = 1;
      step();
      ack = 0;
      chk("d39_ack", sticky_o, 0);

      // prescaled expiry latency
      do_reset();
      cfg(3, 0, 10, 255, 0);
      en = 1;
      n = 0;
      for (int i = 0; i < 200 && !tmo_o; i++) begin
         step();
         n++;
      end
      chk("d40_latency", n, 45);

      // kick on the expiry tick, then ack colliding with set
      do_reset();
      cfg(0, 1, 5, 255, 0);
      en = 1;
      repeat (6) step();
      clr = 1;
      step();
      clr = 0;
      chk("d41_no_pulse", tmo_o, 0);
      chk("d41_no_sticky", sticky_o, 0);
      chk("d41_reload", cnt_o, 1);
      repeat (4) step();
      ack = 1;
      step();
      ack = 0;
      chk("d41_set_wins", sticky_o, 1);
      chk("d41_pulse", tmo_o, 1);

      // pause/resume with warning
      do_reset();
      cfg(1, 0, 6, 3, 0);
      en = 1;
      for (int i = 0; i < 50 && cnt_o != 4; i++) step();
      chk("d42_reach4", cnt_o, 4);
      en = 0;
      step();
      chk("d42_warn_off", warn_o, 0);
      chk("d42_hold", cnt_o, 4);
      step();
      en = 1;
      step();
      chk("d42_warn_on", warn_o, 1);
      chk("d42_resume_a", cnt_o, 4);
      step();
      chk("d42_resume_b", cnt_o, 4);
      step();
      chk("d42_resume_c", cnt_o, 5);

      // reset while expired
      for (int i = 0; i < 50 && !sticky_o; i++) step();
      chk("d43_expired", sticky_o, 1);
      do_reset();
      presc = 0;
      step();
      chk("d43_start", cnt_o, 0);
      step();
      chk("d43_count", cnt_o, 1);

      // randomized traffic
      do_reset();
      cfg(1, 0, 12, 6, 0);
      for (int i = 0; i < 3000; i++) begin
         if (i % 150 == 149) begin
            en = 0; clr = 0; ack = 0;
            presc = PW'($urandom_range(0, 3));
            step();
            continue;
         end
         en  = ($urandom_range(0, 19) != 0);
         clr = ($urandom_range(0, 29) == 0);
         ack = ($urandom_range(0, 14) == 0);
         if ($urandom_range(0, 39) == 0) mode = ~mode;
         if ($urandom_range(0, 49) == 0) tmo_v = W'($urandom_range(0, 20));
         if ($urandom_range(0, 49) == 0) init_v = W'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) warn_v = W'($urandom_range(0, 20));
         if ($urandom_range(0, 299) == 0) tmo_v = 8'd0;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
